win_fetch_ctrl: RTL and testbench

WIN_FETCH_CTRL -- requirements
Module: win_fetch_ctrl

---
 rtl/win_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_win_fetch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/win_fetch_ctrl.sv
// rtl/win_fetch_ctrl.sv - raster-scan 6x6 window fetcher over a row-major pixel memory
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             begin a full-image scan (only acted on when idle)
//   memReaden/memAddr pixel read request, address = y*IMG_W + x
//   memData           read data, returned one cycle after its request
//   window            36 pixels, byte k = r*6+c at [8k+7:8k]
//   winValid/winReady window handshake; winX/winY give the window's top-left
//   busy              high whenever a scan is in progress
//   done              one-cycle pulse after the final window is accepted
module win_fetch_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              memReaden,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [7:0]        memData,
  output logic [287:0]      window,
  output logic              winValid,
  input  logic              winReady,
  output logic [11:0]       winX,
  output logic [11:0]       winY,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [11:0] LAST_X  = 12'(IMG_W - 6);
  localparam logic [11:0] LAST_Y  = 12'(IMG_H - 6);
  localparam logic [31:0] IMG_W_U = 32'(IMG_W);

  state_t        r_state;
  state_t        w_next;
  logic [5:0]    r_k;
  // Row/column of the current fetch within the window, kept alongside r_k
  // so the address needs no divide-by-6.
  logic [2:0]    r_row;
  logic [2:0]    r_col;
  logic [11:0]   r_win_x;
  logic [11:0]   r_win_y;
  logic [287:0]  r_window;
  // Tracks the read issued last cycle so its data lands in the right byte.
  logic          r_cap_vld;
  logic [5:0]    r_cap_idx;
  logic          w_last_x;
  logic          w_last_y;
  logic [31:0]   w_addr_full;

  assign w_last_x = (r_win_x == LAST_X);
  assign w_last_y = (r_win_y == LAST_Y);

  // Full 32-bit arithmetic; only the final result is cut to ADDR_W.
  assign w_addr_full = (32'(r_win_y) + 32'(r_row)) * IMG_W_U
                     + 32'(r_win_x) + 32'(r_col);

  assign memAddr = memReaden ? w_addr_full[ADDR_W-1:0] : '0;
  assign window  = r_window;
  assign winX    = r_win_x;
  assign winY    = r_win_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    memReaden = 1'b0;
    winValid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        memReaden = 1'b1;
        if (r_k == 6'd35) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = S_PRESENT;
      end
      S_PRESENT: begin
        winValid = 1'b1;
        if (winReady) w_next = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_win_x   <= '0;
      r_win_y   <= '0;
      r_window  <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_cap_vld <= memReaden;
      r_cap_idx <= r_k;
      if (r_cap_vld) r_window[{r_cap_idx, 3'b000} +: 8] <= memData;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win_x <= '0;
            r_win_y <= '0;
            r_k     <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_FETCH: begin
          r_k <= r_k + 6'd1;
          if (r_col == 3'd5) begin
            r_col <= '0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        S_PRESENT: begin
          if (winReady) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
            // On the final window the coordinates are left as they are.
            if (!w_last_x) begin
              r_win_x <= r_win_x + 12'd1;
            end else if (!w_last_y) begin
              r_win_x <= '0;
              r_win_y <= r_win_y + 12'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_win_fetch_ctrl.sv
// tb/tb_win_fetch_ctrl.sv - self-checking bench for win_fetch_ctrl on an 8x8 image
module tb_win_fetch_ctrl;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              memReaden;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memData = 8'h00;
  logic [287:0]      window;
  logic              winValid;
  logic              winReady;
  logic [11:0]       winX;
  logic [11:0]       winY;
  logic              busy;
  logic              done;

  win_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .memReaden(memReaden), .memAddr(memAddr), .memData(memData),
    .window(window), .winValid(winValid), .winReady(winReady),
    .winX(winX), .winY(winY), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) memData <= memReaden ? memAddr[7:0] : 8'hA5;

  typedef struct {
    int           x;
    int           y;
    logic [287:0] win;
  } exp_t;

  typedef struct {
    int         win_n;
    int         byte_idx;
    int         exp_x;
    int         exp_y;
    logic [7:0] exp_byte;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [287:0] exp_win(input int x, input int y);
    logic [287:0] w;
    w = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        w[8*(r*6+c) +: 8] = 8'((y + r) * IMG_W + x + c);
    return w;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_memReaden"}, memReaden, 0);
    chk({tag, "_memAddr"},   memAddr,   0);
    chk({tag, "_window"},    window,    0);
    chk({tag, "_winValid"},  winValid,  0);
    chk({tag, "_winX"},      winX,      0);
    chk({tag, "_winY"},      winY,      0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  // Runs one scan. stall_n: handshake index at which winReady is held low for
  // 10 cycles (-1 for none). poke: drive random start pulses while busy.
  // reset_at: read number at which reset is asserted (0 for none).
  task automatic run_scan(input int stall_n, input bit poke, input int reset_at,
                          output bit aborted);
    int cyc = 0, rd = 0, rk = 0, n = 0, first_valid = -1, first_rd = -1;
    int stall_cnt = 0, addr_err = 0;
    bit seen_done = 0, fin = 0;
    logic [311:0] snap;
    exp_t e;
    int ea;
    aborted = 0;
    for (int y = 0; y <= IMG_H - 6; y++)
      for (int x = 0; x <= IMG_W - 6; x++) begin
        e.x = x; e.y = y; e.win = exp_win(x, y);
        sb_q.push_back(e);
      end
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      cyc++;
      if (memReaden) begin
        rd++;
        if (first_rd < 0) first_rd = cyc;
        if (sb_q.size() == 0) addr_err++;
        else begin
          ea = (sb_q[0].y + rk / 6) * IMG_W + sb_q[0].x + rk % 6;
          if (int'(memAddr) != ea) addr_err++;
        end
        rk++;
        if (rd == reset_at) begin
          chk("abort_addr", memAddr, 28);
          reset   = 1'b1;
          start   = 1'b0;
          aborted = 1;
          sb_q.delete();
          return;
        end
      end
      if (winValid && first_valid < 0) first_valid = cyc;
      if (winValid && n == stall_n && stall_cnt < 10) begin
        if (stall_cnt == 0) snap = {window, winX, winY};
        else chk("stall_hold", {window, winX, winY, memReaden, winValid}, {snap, 2'b01});
        winReady = 1'b0;
        stall_cnt++;
      end else begin
        winReady = 1'b1;
      end
      if (winValid && winReady) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("win_data", window, e.win);
          chk("win_xy", {winX, winY}, {12'(e.x), 12'(e.y)});
        end
        n++;
        for (int i = 0; i < 6; i++)
          if (vecs[i].win_n == n) begin
            chk("vec_byte", window[8*vecs[i].byte_idx +: 8], vecs[i].exp_byte);
            chk("vec_xy", {winX, winY}, {12'(vecs[i].exp_x), 12'(vecs[i].exp_y)});
          end
        rk = 0;
      end
      if (seen_done) begin
        chk("done_width", done, 0);
        chk("idle_busy", busy, 0);
        fin = 1;
      end else if (done) begin
        seen_done = 1;
        chk("done_after_last", n, (IMG_W - 5) * (IMG_H - 5));
        start = 1'b0;
      end else begin
        start = poke ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
    start = 1'b0;
    if (!fin) chk("scan_timeout", 0, 1);
    chk("first_rd_latency", first_rd, 1);
    chk("winvalid_latency", first_valid, 38);
    chk("read_count", rd, 324);
    chk("window_count", n, 9);
    chk("addr_seq_errors", addr_err, 0);
    chk("sb_leftover", sb_q.size(), 0);
  endtask

  bit ab;

  initial begin
    vecs[0] = '{1, 0,  0, 0, 8'd0};
    vecs[1] = '{1, 6,  0, 0, 8'd8};
    vecs[2] = '{1, 35, 0, 0, 8'd45};
    vecs[3] = '{2, 0,  1, 0, 8'd1};
    vecs[4] = '{4, 0,  0, 1, 8'd8};
    vecs[5] = '{9, 35, 2, 2, 8'd63};

    reset = 1'b1; start = 1'b0; winReady = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;

    run_scan(-1, 1'b0, 0, ab);
    run_scan(4, 1'b1, 0, ab);

    run_scan(-1, 1'b0, 93, ab);
    chk("aborted", ab, 1);
    @(negedge clk);
    chk_reset("mid_rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_data_dropped", window, 0);
    chk("post_rst_idle", busy, 0);

    run_scan(-1, 1'b0, 0, ab);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
